// File: rtl/score_keeper_pkg.sv
// Shared definitions for the score keeper: FSM state encoding, score width, no-winner code.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package score_keeper_pkg;

    localparam int SCORE_W = 7;

    localparam logic [2:0] NO_WINNER = 3'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Player numbers are 1..4; storage slots are 0..3. Player 4 (3'b100)
    // maps to slot 3 because the low two bits wrap 00 - 1 -> 11.
    function automatic logic [1:0] player_slot(input logic [2:0] player);
        return player[1:0] - 2'd1;
    endfunction

endpackage

// File: rtl/score_sat.sv
// Saturating add/subtract of one score: +ADD_PTS clamped to MAX_SCORE, -SUB_PTS clamped to 0.
// Latency: combinational, zero cycles.
// Backpressure: none; add has priority if both requests are raised.
// Ports: score_in (current score), add/sub (operation requests), score_out (result).
// Macro SCORE_PENALTY_EN: when undefined the subtract path is not built and sub is ignored.
module score_sat
    import score_keeper_pkg::*;
#(
    parameter int ADD_PTS   = 1,
    parameter int SUB_PTS   = 1,
    parameter int MAX_SCORE = 99
) (
    input  logic [SCORE_W-1:0] score_in,
    input  logic               add,
    input  logic               sub,
    output logic [SCORE_W-1:0] score_out
);

    // One extra bit so the sum cannot wrap before the ceiling compare.
    localparam logic [SCORE_W:0] ADD_V = (SCORE_W+1)'(ADD_PTS);
    localparam logic [SCORE_W:0] SUB_V = (SCORE_W+1)'(SUB_PTS);
    localparam logic [SCORE_W:0] MAX_V = (SCORE_W+1)'(MAX_SCORE);

    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] add_res;

    assign sum     = {1'b0, score_in} + ADD_V;
    assign add_res = (sum > MAX_V) ? MAX_V[SCORE_W-1:0] : sum[SCORE_W-1:0];

`ifdef SCORE_PENALTY_EN
    logic [SCORE_W:0]   diff;
    logic [SCORE_W-1:0] sub_res;

    assign diff    = {1'b0, score_in} - SUB_V;
    assign sub_res = ({1'b0, score_in} < SUB_V) ? '0 : diff[SCORE_W-1:0];

    always_comb begin
        score_out = score_in;
        if (add) begin
            score_out = add_res;
        end else if (sub) begin
            score_out = sub_res;
        end
    end
`else
    // Port list and parameters stay identical in both builds.
    logic unused_sub;
    assign unused_sub = ^{sub, SUB_V};

    always_comb begin
        score_out = score_in;
        if (add) begin
            score_out = add_res;
        end
    end
`endif

endmodule

// File: rtl/score_keeper.sv
// Score keeper for 1..4 players: award/penalty events, target win or round-limit scan for leader.
// Latency: events visible 1 cycle later; round-limit result player_count+1 cycles after the last award.
// Backpressure: none; events outside PLAY, to invalid players, or coincident award+penalty are dropped.
// Ports: clk, rst (async active-low), start/player_count/target_score (new game),
//        award/penalty/evt_player (events), player1..4_score, winner, game_over, busy.
// Macro SCORE_PENALTY_EN: when undefined, penalty is ignored and no subtract logic exists.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int ADD_PTS    = 1,
    parameter int SUB_PTS    = 1,
    parameter int MAX_SCORE  = 99,
    parameter int MAX_ROUNDS = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         player_count,
    input  logic [SCORE_W-1:0] target_score,
    input  logic               award,
    input  logic               penalty,
    input  logic [2:0]         evt_player,
    output logic [SCORE_W-1:0] player1_score,
    output logic [SCORE_W-1:0] player2_score,
    output logic [SCORE_W-1:0] player3_score,
    output logic [SCORE_W-1:0] player4_score,
    output logic [2:0]         winner,
    output logic               game_over,
    output logic               busy
);

    localparam int RND_NEED = $clog2(MAX_ROUNDS + 1);
    localparam int RND_BITS = (RND_NEED > 5) ? RND_NEED : 5;
    localparam logic [RND_BITS-1:0] RND_LIMIT = RND_BITS'(MAX_ROUNDS);

    logic [1:0]          state_q;
    logic [SCORE_W-1:0]  score_q [4];
    logic [RND_BITS-1:0] rnd_q;
    logic [RND_BITS-1:0] rnd_inc;
    logic [2:0]          cnt_q;
    logic [SCORE_W-1:0]  tgt_q;
    logic [2:0]          winner_q;
    logic                game_over_q;
    logic [2:0]          scan_q;
    logic [2:0]          lead_q;
    logic [SCORE_W-1:0]  lead_score_q;

    logic                pen_in;
    logic                ev_ok;
    logic                award_ok;
    logic                pen_ok;
    logic [1:0]          evt_slot;
    logic [1:0]          scan_slot;
    logic [SCORE_W-1:0]  sat_score;
    logic                round_limit;

`ifdef SCORE_PENALTY_EN
    assign pen_in = penalty;
`else
    logic unused_penalty;
    assign unused_penalty = penalty;
    assign pen_in         = 1'b0;
`endif

    // cnt_q is held within 1..4, so this bound also rejects players 5..7.
    assign ev_ok    = (state_q == ST_PLAY) && !start &&
                      (evt_player != 3'd0) && (evt_player <= cnt_q);
    assign award_ok = ev_ok && award && !pen_in;
    assign pen_ok   = ev_ok && pen_in && !award;

    assign evt_slot  = player_slot(evt_player);
    assign scan_slot = player_slot(scan_q);

    score_sat #(
        .ADD_PTS   (ADD_PTS),
        .SUB_PTS   (SUB_PTS),
        .MAX_SCORE (MAX_SCORE)
    ) u_sat (
        .score_in  (score_q[evt_slot]),
        .add       (award_ok),
        .sub       (pen_ok),
        .score_out (sat_score)
    );

    // Saturating increment only matters when the round limit is disabled.
    assign rnd_inc     = (&rnd_q) ? rnd_q : rnd_q + RND_BITS'(1);
    assign round_limit = (MAX_ROUNDS != 0) && (rnd_inc == RND_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < 4; i++) score_q[i] <= '0;
            rnd_q        <= '0;
            cnt_q        <= '0;
            tgt_q        <= '0;
            winner_q     <= NO_WINNER;
            game_over_q  <= 1'b0;
            scan_q       <= '0;
            lead_q       <= NO_WINNER;
            lead_score_q <= '0;
        end else begin
            game_over_q <= 1'b0;
            if (start) begin
                for (int i = 0; i < 4; i++) score_q[i] <= '0;
                rnd_q    <= '0;
                winner_q <= NO_WINNER;
                tgt_q    <= target_score;
                // Out-of-range counts are pulled into 1..4 so SCAN always terminates.
                if (player_count == 3'd0) begin
                    cnt_q <= 3'd1;
                end else if (player_count > 3'd4) begin
                    cnt_q <= 3'd4;
                end else begin
                    cnt_q <= player_count;
                end
                state_q <= ST_PLAY;
            end else begin
                case (state_q)
                    ST_PLAY: begin
                        if (award_ok || pen_ok) begin
                            score_q[evt_slot] <= sat_score;
                        end
                        if (award_ok) begin
                            rnd_q <= rnd_inc;
                            if (sat_score >= tgt_q) begin
                                winner_q    <= evt_player;
                                game_over_q <= 1'b1;
                                state_q     <= ST_DONE;
                            end else if (round_limit) begin
                                scan_q  <= 3'd1;
                                state_q <= ST_SCAN;
                            end
                        end
                    end
                    ST_SCAN: begin
                        if (scan_q <= cnt_q) begin
                            // Player 1 seeds the leader; only a strictly higher
                            // score displaces it, so ties stay with the lower index.
                            if ((scan_q == 3'd1) || (score_q[scan_slot] > lead_score_q)) begin
                                lead_q       <= scan_q;
                                lead_score_q <= score_q[scan_slot];
                            end
                            scan_q <= scan_q + 3'd1;
                        end else begin
                            winner_q    <= lead_q;
                            game_over_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                    default: begin
                        // IDLE waits for start; DONE holds scores and winner.
                    end
                endcase
            end
        end
    end

    assign player1_score = score_q[0];
    assign player2_score = score_q[1];
    assign player3_score = score_q[2];
    assign player4_score = score_q[3];
    assign winner        = winner_q;
    assign game_over     = game_over_q;
    assign busy          = (state_q == ST_PLAY) || (state_q == ST_SCAN);

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper: two instances (round-limited, and large-step saturating)
// driven by directed scenarios then random events, compared with a game-level model.
// Honours SCORE_PENALTY_EN in its expectations.
module tb_score_keeper;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_SCAN = 2;
    localparam int M_DONE = 3;

`ifdef SCORE_PENALTY_EN
    localparam bit PEN_EN = 1'b1;
`else
    localparam bit PEN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] player_count;
    logic [6:0] tgt0, tgt1;
    logic       award;
    logic       penalty;
    logic [2:0] evt_player;

    logic [6:0] d0_s1, d0_s2, d0_s3, d0_s4, d1_s1, d1_s2, d1_s3, d1_s4;
    logic [2:0] d0_win, d1_win;
    logic       d0_go, d1_go, d0_busy, d1_busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    score_keeper #(.ADD_PTS(1), .SUB_PTS(1), .MAX_SCORE(99), .MAX_ROUNDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .player_count(player_count),
        .target_score(tgt0), .award(award), .penalty(penalty), .evt_player(evt_player),
        .player1_score(d0_s1), .player2_score(d0_s2), .player3_score(d0_s3),
        .player4_score(d0_s4), .winner(d0_win), .game_over(d0_go), .busy(d0_busy)
    );

    score_keeper #(.ADD_PTS(40), .SUB_PTS(30), .MAX_SCORE(99), .MAX_ROUNDS(0)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .player_count(player_count),
        .target_score(tgt1), .award(award), .penalty(penalty), .evt_player(evt_player),
        .player1_score(d1_s1), .player2_score(d1_s2), .player3_score(d1_s3),
        .player4_score(d1_s4), .winner(d1_win), .game_over(d1_go), .busy(d1_busy)
    );

    function automatic int p_add(input int m); return (m == 0) ? 1 : 40; endfunction
    function automatic int p_sub(input int m); return (m == 0) ? 1 : 30; endfunction
    function automatic int p_max(input int m); return 99; endfunction
    function automatic int p_rnd(input int m); return (m == 0) ? 4 : 0; endfunction

    // Game-level model: per instance scores, rounds, phase, and a scan countdown.
    int msc  [2][5];
    int mph  [2];
    int mrnd [2];
    int mcnt [2];
    int mtgt [2];
    int mwin [2];
    int mgo  [2];
    int mleft[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 5; p++) msc[m][p] = 0;
            mph[m] = M_IDLE; mrnd[m] = 0; mcnt[m] = 0; mtgt[m] = 0;
            mwin[m] = 0; mgo[m] = 0; mleft[m] = 0;
        end
    endtask

    task automatic model_edge();
        int  e;
        int  best;
        bit  pen;
        for (int m = 0; m < 2; m++) begin
            mgo[m] = 0;
            e   = int'(evt_player);
            pen = PEN_EN && penalty;
            if (start) begin
                for (int p = 0; p < 5; p++) msc[m][p] = 0;
                mrnd[m] = 0;
                mwin[m] = 0;
                mcnt[m] = int'(player_count);
                mtgt[m] = (m == 0) ? int'(tgt0) : int'(tgt1);
                mph[m]  = M_PLAY;
            end else if (mph[m] == M_PLAY) begin
                if (e >= 1 && e <= mcnt[m]) begin
                    if (award && !pen) begin
                        msc[m][e] = msc[m][e] + p_add(m);
                        if (msc[m][e] > p_max(m)) msc[m][e] = p_max(m);
                        mrnd[m]++;
                        if (msc[m][e] >= mtgt[m]) begin
                            mwin[m] = e; mgo[m] = 1; mph[m] = M_DONE;
                        end else if (p_rnd(m) != 0 && mrnd[m] == p_rnd(m)) begin
                            mph[m] = M_SCAN; mleft[m] = mcnt[m] + 1;
                        end
                    end else if (pen && !award) begin
                        msc[m][e] = msc[m][e] - p_sub(m);
                        if (msc[m][e] < 0) msc[m][e] = 0;
                    end
                end
            end else if (mph[m] == M_SCAN) begin
                mleft[m]--;
                if (mleft[m] == 0) begin
                    best = 1;
                    for (int p = 2; p <= mcnt[m]; p++) if (msc[m][p] > msc[m][best]) best = p;
                    mwin[m] = best; mgo[m] = 1; mph[m] = M_DONE;
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        logic [6:0] s [2][5];
        logic [2:0] w [2];
        logic       g [2];
        logic       b [2];
        s[0][1] = d0_s1; s[0][2] = d0_s2; s[0][3] = d0_s3; s[0][4] = d0_s4;
        s[1][1] = d1_s1; s[1][2] = d1_s2; s[1][3] = d1_s3; s[1][4] = d1_s4;
        w[0] = d0_win; w[1] = d1_win; g[0] = d0_go; g[1] = d1_go;
        b[0] = d0_busy; b[1] = d1_busy;
        for (int m = 0; m < 2; m++) begin
            for (int p = 1; p <= 4; p++)
                chk($sformatf("%s_i%0d_p%0d", ctx, m, p), 32'(s[m][p]), msc[m][p]);
            chk($sformatf("%s_i%0d_winner", ctx, m), 32'(w[m]), mwin[m]);
            chk($sformatf("%s_i%0d_game_over", ctx, m), 32'(g[m]), mgo[m]);
            chk($sformatf("%s_i%0d_busy", ctx, m), 32'(b[m]),
                (mph[m] == M_PLAY || mph[m] == M_SCAN) ? 1 : 0);
        end
    endtask

    // Drive at the falling edge, step the model at the rising edge, compare at the next falling edge.
    task automatic cyc(input string ctx, input logic s, input logic [2:0] c,
                       input logic a, input logic p, input logic [2:0] e);
        start = s; player_count = c; award = a; penalty = p; evt_player = e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(ctx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int       lat;
        logic [2:0] rc;
        logic     rs;

        rst = 1'b0; start = 1'b0; player_count = 3'd0; tgt0 = 7'd0; tgt1 = 7'd0;
        award = 1'b0; penalty = 1'b0; evt_player = 3'd0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset_busy", 32'(d0_busy), 0);
        chk("reset_winner", 32'(d0_win), 0);
        @(negedge clk);
        rst = 1'b1;

        // Events in IDLE are ignored.
        cyc("idle", 0, 3'd2, 1, 0, 3'd1);
        chk("idle_award_p1", 32'(d0_s1), 0);

        // Three awards to P2 reach target 3; the large-step instance saturates at 99.
        tgt0 = 7'd3; tgt1 = 7'd99;
        cyc("start_a", 1, 3'd2, 0, 0, 3'd0);
        chk("start_busy", 32'(d0_busy), 1);
        cyc("win_a", 0, 3'd2, 1, 0, 3'd2);
        cyc("win_a", 0, 3'd2, 1, 0, 3'd2);
        cyc("win_a", 0, 3'd2, 1, 0, 3'd2);
        chk("win_p2_score", 32'(d0_s2), 3);
        chk("win_winner", 32'(d0_win), 2);
        chk("win_game_over", 32'(d0_go), 1);
        chk("sat_p2_score", 32'(d1_s2), 99);
        cyc("done_a", 0, 3'd2, 1, 0, 3'd2);
        chk("done_go_pulse", 32'(d0_go), 0);
        chk("done_busy", 32'(d0_busy), 0);
        chk("done_hold_p2", 32'(d0_s2), 3);

        // Penalty floor at 0, then penalty from 2.
        tgt0 = 7'd50; tgt1 = 7'd99;
        cyc("start_b", 1, 3'd2, 0, 0, 3'd0);
        cyc("pen0", 0, 3'd2, 0, 1, 3'd1);
        chk("pen_at_zero", 32'(d0_s1), 0);
        cyc("pen_b", 0, 3'd2, 1, 0, 3'd1);
        cyc("pen_b", 0, 3'd2, 1, 0, 3'd1);
        cyc("pen_b", 0, 3'd2, 0, 1, 3'd1);
        chk("pen_from_two", 32'(d0_s1), PEN_EN ? 1 : 2);
        chk("sat_pen_from_80", 32'(d1_s1), PEN_EN ? 50 : 80);

        // Coincident award+penalty, then start together with award.
        cyc("coinc", 0, 3'd2, 1, 1, 3'd2);
        chk("coinc_p2", 32'(d0_s2), PEN_EN ? 0 : 1);
        cyc("start_aw", 1, 3'd2, 1, 0, 3'd1);
        chk("start_aw_p1", 32'(d0_s1), 0);
        chk("start_aw_busy", 32'(d0_busy), 1);

        // Invalid players: no score change and no round consumed.
        cyc("inval", 0, 3'd2, 1, 0, 3'd3);
        cyc("inval", 0, 3'd2, 1, 0, 3'd0);
        chk("inval_p3", 32'(d0_s3), 0);
        cyc("inval_r", 0, 3'd2, 1, 0, 3'd1);
        cyc("inval_r", 0, 3'd2, 1, 0, 3'd2);
        cyc("inval_r", 0, 3'd2, 1, 0, 3'd1);
        cyc("inval_r", 0, 3'd2, 1, 0, 3'd2);
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            cyc("scan_c2", 0, 3'd2, 0, 0, 3'd0);
            if (d0_go === 1'b1) lat = k;
        end
        chk("scan_latency_c2", 32'(lat), 3);
        chk("scan_winner_c2", 32'(d0_win), 1);

        // Round limit with three players and a tie between P1 and P3.
        tgt0 = 7'd50; tgt1 = 7'd99;
        cyc("start_c", 1, 3'd3, 0, 0, 3'd0);
        cyc("rounds", 0, 3'd3, 1, 0, 3'd1);
        cyc("rounds", 0, 3'd3, 1, 0, 3'd3);
        cyc("rounds", 0, 3'd3, 1, 0, 3'd3);
        cyc("rounds", 0, 3'd3, 1, 0, 3'd1);
        chk("scan_busy", 32'(d0_busy), 1);
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            cyc("scan_c3", 0, 3'd3, 1, 0, 3'd2);
            if (d0_go === 1'b1) lat = k;
        end
        chk("scan_latency_c3", 32'(lat), 4);
        chk("scan_tie_winner", 32'(d0_win), 1);
        chk("scan_ignored_p2", 32'(d0_s2), 0);

        // Asynchronous reset in the middle of a game.
        cyc("start_d", 1, 3'd2, 0, 0, 3'd0);
        cyc("pre_rst", 0, 3'd2, 1, 0, 3'd1);
        cyc("pre_rst", 0, 3'd2, 1, 0, 3'd2);
        cyc("pre_rst", 0, 3'd2, 1, 0, 3'd2);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_p2", 32'(d0_s2), 0);
        chk("async_rst_busy", 32'(d0_busy), 0);
        @(negedge clk);
        rst = 1'b1;
        cyc("post_rst", 0, 3'd2, 1, 0, 3'd1);
        chk("post_rst_p1", 32'(d0_s1), 0);
        chk("post_rst_busy", 32'(d0_busy), 0);

        // Random play.
        rc = 3'd2;
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 19) == 0);
            if (rs) begin
                tgt0 = 7'($urandom_range(1, 6));
                tgt1 = 7'($urandom_range(1, 99));
                rc   = 3'($urandom_range(1, 4));
            end
            cyc("rand", rs, rc, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                3'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
